mqnic_rx_indir_tbl_fill: RTL and testbench

MQNIC_RX_INDIR_TBL_FILL -- requirements
Module: mqnic_rx_indir_tbl_fill

---
 rtl/mqnic_rx_indir_tbl_fill_pkg.sv | 14 +
 rtl/mqnic_rx_indir_tbl_fill_if.sv | 37 +++
 rtl/mqnic_rx_indir_tbl_fill.sv | 162 ++++++++++++++++
 tb/tb_mqnic_rx_indir_tbl_fill.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mqnic_rx_indir_tbl_fill_pkg.sv
// Shared constants for the RX indirection table fill engine: FSM encoding
// and the fixed AXI-Lite response/protection codes it uses.
package mqnic_rx_indir_tbl_fill_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam logic [2:0] AXIL_AWPROT   = 3'b010;

endpackage

// File: rtl/mqnic_rx_indir_tbl_fill_if.sv
// AXI-Lite write channel (AW/W/B) used by the indirection table fill engine.
interface mqnic_rx_indir_tbl_fill_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);

    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/mqnic_rx_indir_tbl_fill.sv
// Fills one port's RSS indirection table over AXI-Lite, spreading entries
// round-robin across a contiguous range of queues, one write in flight at a time.
module mqnic_rx_indir_tbl_fill
    import mqnic_rx_indir_tbl_fill_pkg::*;
#(
    parameter int          PORTS                = 1,
    parameter int          INDIR_TBL_ADDR_WIDTH = 8,
    parameter int          QUEUE_INDEX_WIDTH    = 10,
    parameter int          AXIL_DATA_WIDTH      = 32,
    parameter int          AXIL_ADDR_WIDTH      = $clog2(PORTS) + INDIR_TBL_ADDR_WIDTH + 2,
    parameter int unsigned AXIL_BASE_ADDR       = 0
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic                                      abort,
    input  logic [((PORTS > 1) ? $clog2(PORTS) : 1)-1:0] cfg_port,
    input  logic [QUEUE_INDEX_WIDTH-1:0]              cfg_queue_base,
    input  logic [QUEUE_INDEX_WIDTH:0]                cfg_queue_count,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      error,
    mqnic_rx_indir_tbl_fill_if.master                 m_axil
);

    localparam int PORT_W = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int ITW    = INDIR_TBL_ADDR_WIDTH;
    localparam int QW     = QUEUE_INDEX_WIDTH;
    localparam int AW     = AXIL_ADDR_WIDTH;

    state_t              state_q, state_d;
    logic [ITW-1:0]      index_q, index_d;
    logic [QW-1:0]       offset_q, offset_d;
    logic [QW-1:0]       base_q, base_d;
    logic [QW:0]         count_q, count_d;
    logic [PORT_W-1:0]   port_q, port_d;
    logic                error_q, error_d;
    logic                abort_pending_q, abort_pending_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                done_q, done_d;

    logic [QW:0]         offset_inc;
    logic [QW-1:0]       queue_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            index_q         <= '0;
            offset_q        <= '0;
            base_q          <= '0;
            count_q         <= '0;
            port_q          <= '0;
            error_q         <= 1'b0;
            abort_pending_q <= 1'b0;
            awvalid_q       <= 1'b0;
            wvalid_q        <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            index_q         <= index_d;
            offset_q        <= offset_d;
            base_q          <= base_d;
            count_q         <= count_d;
            port_q          <= port_d;
            error_q         <= error_d;
            abort_pending_q <= abort_pending_d;
            awvalid_q       <= awvalid_d;
            wvalid_q        <= wvalid_d;
            done_q          <= done_d;
        end
    end

    // Offset wraps by comparison against the latched count, avoiding a modulo.
    assign offset_inc = {1'b0, offset_q} + {{QW{1'b0}}, 1'b1};

    always_comb begin
        state_d         = state_q;
        index_d         = index_q;
        offset_d        = offset_q;
        base_d          = base_q;
        count_d         = count_q;
        port_d          = port_q;
        error_d         = error_q;
        abort_pending_d = abort_pending_q;
        awvalid_d       = awvalid_q;
        wvalid_d        = wvalid_q;
        done_d          = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    port_d          = (int'(cfg_port) >= PORTS) ? '0 : cfg_port;
                    base_d          = cfg_queue_base;
                    count_d         = (cfg_queue_count == '0) ? {{QW{1'b0}}, 1'b1} : cfg_queue_count;
                    index_d         = '0;
                    offset_d        = '0;
                    error_d         = 1'b0;
                    abort_pending_d = 1'b0;
                    awvalid_d       = 1'b1;
                    wvalid_d        = 1'b1;
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    abort_pending_d = 1'b1;
                end
                if (awvalid_q && m_axil.awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && m_axil.wready) begin
                    wvalid_d = 1'b0;
                end
                if ((!awvalid_q || m_axil.awready) && (!wvalid_q || m_axil.wready)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (abort) begin
                    abort_pending_d = 1'b1;
                end
                if (m_axil.bvalid) begin
                    if (m_axil.bresp != AXI_RESP_OKAY) begin
                        error_d = 1'b1;
                    end
                    if ((index_q == '1) || abort_pending_q) begin
                        abort_pending_d = 1'b0;
                        done_d          = 1'b1;
                        state_d         = IDLE;
                    end else begin
                        index_d   = index_q + 1'b1;
                        offset_d  = (offset_inc == count_q) ? '0 : offset_inc[QW-1:0];
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ISSUE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign queue_sum = base_q + offset_q;

    assign m_axil.awaddr  = AW'(AXIL_BASE_ADDR)
                          + (AW'(port_q) << (ITW + 2))
                          + (AW'(index_q) << 2);
    assign m_axil.awprot  = AXIL_AWPROT;
    assign m_axil.awvalid = awvalid_q;
    assign m_axil.wdata   = AXIL_DATA_WIDTH'(queue_sum);
    assign m_axil.wstrb   = '1;
    assign m_axil.wvalid  = wvalid_q;
    assign m_axil.bready  = (state_q == RESP);

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign error = error_q;

endmodule

// File: tb/tb_mqnic_rx_indir_tbl_fill.sv
// Directed bench for mqnic_rx_indir_tbl_fill: a behavioural AXI-Lite slave with
// programmable ready/response delays records every write for later comparison.
module tb_mqnic_rx_indir_tbl_fill;

    localparam int PORTS = 2;
    localparam int ITW   = 2;
    localparam int QW    = 10;
    localparam int DW    = 32;
    localparam int AW    = $clog2(PORTS) + ITW + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [0:0]    cfg_port = '0;
    logic [QW-1:0] cfg_queue_base = '0;
    logic [QW:0]   cfg_queue_count = '0;
    logic          busy;
    logic          done;
    logic          error;

    int vectors;
    int miscompares;

    int aw_delay;
    int w_delay;
    int b_delay;
    int err_idx;

    int          nwr;
    int          viol;
    logic [AW-1:0] wr_addr [16];
    logic [31:0]   wr_data [16];

    mqnic_rx_indir_tbl_fill_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axil ();

    mqnic_rx_indir_tbl_fill #(
        .PORTS                (PORTS),
        .INDIR_TBL_ADDR_WIDTH (ITW),
        .QUEUE_INDEX_WIDTH    (QW),
        .AXIL_DATA_WIDTH      (DW),
        .AXIL_ADDR_WIDTH      (AW),
        .AXIL_BASE_ADDR       (0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .cfg_port        (cfg_port),
        .cfg_queue_base  (cfg_queue_base),
        .cfg_queue_count (cfg_queue_count),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .m_axil          (axil)
    );

    always #5 clk = ~clk;

    // Slave: decides readiness at each negedge so the handshake lands on the next posedge.
    initial begin
        int  aw_cnt;
        int  w_cnt;
        int  b_cnt;
        bit  aw_got;
        bit  w_got;
        logic [AW-1:0] last_addr;
        logic [31:0]   last_data;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; aw_got = 0; w_got = 0;
        last_addr = '0; last_data = '0;
        nwr = 0; viol = 0;
        axil.awready = 1'b0;
        axil.wready  = 1'b0;
        axil.bvalid  = 1'b0;
        axil.bresp   = 2'b00;
        forever begin
            @(negedge clk);
            axil.awready = 1'b0;
            axil.wready  = 1'b0;
            if (rst) begin
                axil.bvalid = 1'b0;
                axil.bresp  = 2'b00;
                nwr = 0; viol = 0;
                aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            end else if (axil.bvalid) begin
                axil.bvalid = 1'b0;
                axil.bresp  = 2'b00;
                aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                nwr++;
            end else begin
                if (axil.awvalid) begin
                    if (aw_got) begin
                        viol++;
                    end else begin
                        if (aw_cnt > 0 && axil.awaddr !== last_addr) viol++;
                        last_addr = axil.awaddr;
                        if (aw_cnt >= aw_delay) begin
                            axil.awready = 1'b1;
                            aw_got = 1;
                            if (nwr < 16) wr_addr[nwr] = axil.awaddr;
                        end else begin
                            aw_cnt++;
                        end
                    end
                end else if (aw_cnt > 0 && !aw_got) begin
                    viol++;
                end
                if (axil.wvalid) begin
                    if (w_got) begin
                        viol++;
                    end else begin
                        if (w_cnt > 0 && axil.wdata !== last_data) viol++;
                        last_data = axil.wdata;
                        if (w_cnt >= w_delay) begin
                            axil.wready = 1'b1;
                            w_got = 1;
                            if (nwr < 16) wr_data[nwr] = axil.wdata;
                        end else begin
                            w_cnt++;
                        end
                    end
                end else if (w_cnt > 0 && !w_got) begin
                    viol++;
                end
                if (aw_got && w_got && axil.bready) begin
                    if (b_cnt >= b_delay) begin
                        axil.bvalid = 1'b1;
                        axil.bresp  = (nwr == err_idx) ? 2'b10 : 2'b00;
                    end else begin
                        b_cnt++;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Pulses start and checks the first ISSUE cycle: both valids up, error cleared.
    task automatic applyStimulus(input logic [0:0] port, input logic [QW-1:0] base,
                                 input logic [QW:0] count, input logic with_abort);
        @(negedge clk);
        cfg_port        = port;
        cfg_queue_base  = base;
        cfg_queue_count = count;
        start           = 1'b1;
        abort           = with_abort;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("issue_busy", busy, 1);
        checkOutput("issue_awvalid", axil.awvalid, 1);
        checkOutput("issue_wvalid", axil.wvalid, 1);
        checkOutput("issue_awprot", axil.awprot, 3'b010);
        checkOutput("issue_wstrb", axil.wstrb, 4'hF);
        checkOutput("issue_error_clear", error, 0);
        checkOutput("issue_awaddr", axil.awaddr, 32'(port) * 16);
    endtask

    task automatic waitDone(input int max_cycles);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < max_cycles) begin
            if (done) seen = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput("done_seen", seen, 1);
        if (seen) begin
            checkOutput("done_busy_low", busy, 0);
            @(negedge clk);
            checkOutput("done_one_cycle", done, 0);
        end
    endtask

    initial begin
        int exp_data [4];
        int ep;
        int n;
        int done_cnt;
        bit prev;
        exp_data[0] = 8; exp_data[1] = 9; exp_data[2] = 10; exp_data[3] = 8;
        vectors = 0;
        miscompares = 0;
        aw_delay = 0; w_delay = 0; b_delay = 0; err_idx = -1;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_awvalid", axil.awvalid, 0);
        checkOutput("rst_wvalid", axil.wvalid, 0);
        checkOutput("rst_bready", axil.bready, 0);
        rst = 1'b0;

        $display("[TB] default fill");
        applyStimulus(1'b0, 10'd8, 11'd3, 1'b0);
        waitDone(200);
        checkOutput("s1_nwr", nwr, 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("s1_addr%0d", i), 32'(wr_addr[i]), 32'(i * 4));
            checkOutput($sformatf("s1_data%0d", i), wr_data[i], 32'(exp_data[i]));
        end
        checkOutput("s1_error", error, 0);
        checkOutput("s1_viol", viol, 0);

        $display("[TB] port select, zero count");
        doReset();
        applyStimulus(1'b1, 10'd0, 11'd0, 1'b0);
        waitDone(200);
        checkOutput("s2_nwr", nwr, 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("s2_addr%0d", i), 32'(wr_addr[i]), 32'(16 + i * 4));
            checkOutput($sformatf("s2_data%0d", i), wr_data[i], 0);
        end

        $display("[TB] backpressure");
        doReset();
        aw_delay = 3; w_delay = 1; b_delay = 5;
        applyStimulus(1'b0, 10'd8, 11'd3, 1'b0);
        waitDone(400);
        checkOutput("s3_nwr", nwr, 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("s3_addr%0d", i), 32'(wr_addr[i]), 32'(i * 4));
            checkOutput($sformatf("s3_data%0d", i), wr_data[i], 32'(exp_data[i]));
        end
        checkOutput("s3_viol", viol, 0);

        $display("[TB] error response");
        doReset();
        aw_delay = 0; w_delay = 0; b_delay = 0; err_idx = 1;
        applyStimulus(1'b0, 10'd8, 11'd3, 1'b0);
        waitDone(200);
        checkOutput("s4_nwr", nwr, 4);
        checkOutput("s4_error_set", error, 1);
        repeat (3) @(negedge clk);
        checkOutput("s4_error_sticky", error, 1);
        err_idx = -1;
        applyStimulus(1'b0, 10'd8, 11'd3, 1'b0);
        waitDone(200);
        checkOutput("s4_error_after_clean", error, 0);

        $display("[TB] abort");
        doReset();
        b_delay = 5;
        applyStimulus(1'b0, 10'd8, 11'd3, 1'b0);
        ep = 0; n = 0; prev = 0;
        while (ep < 2 && n < 200) begin
            if (axil.bready && !prev) ep++;
            prev = axil.bready;
            if (ep < 2) begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput("s5_second_resp", ep, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        waitDone(200);
        checkOutput("s5_nwr", nwr, 2);
        checkOutput("s5_addr0", 32'(wr_addr[0]), 0);
        checkOutput("s5_addr1", 32'(wr_addr[1]), 4);
        b_delay = 0;
        applyStimulus(1'b0, 10'd8, 11'd3, 1'b0);
        waitDone(200);
        checkOutput("s5_refill_nwr", nwr, 6);
        checkOutput("s5_refill_addr", 32'(wr_addr[2]), 0);
        checkOutput("s5_refill_data", wr_data[2], 8);

        $display("[TB] reset mid-issue");
        doReset();
        aw_delay = 3;
        applyStimulus(1'b0, 10'd8, 11'd3, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("s6_awvalid", axil.awvalid, 0);
        checkOutput("s6_wvalid", axil.wvalid, 0);
        checkOutput("s6_busy", busy, 0);
        checkOutput("s6_done", done, 0);
        rst = 1'b0;
        done_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        checkOutput("s6_no_done", done_cnt, 0);

        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        checkOutput("s6_rst_over_start", busy, 0);
        @(negedge clk);
        checkOutput("s6_still_idle", busy, 0);

        $display("[TB] start with abort in idle");
        aw_delay = 0;
        applyStimulus(1'b0, 10'd8, 11'd3, 1'b1);
        waitDone(200);
        checkOutput("s7_nwr", nwr, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
